// File: rtl/branch_seq.sv
// branch_seq: ID-stage branch resolution sequencer.
// Stalls IF/ID while branch operands are still being forwarded, then issues a
// one-cycle redirect to the branch target one cycle after the decision edge,
// so the delay slot is fetched at the decision edge and the target after it.
// Optional feature macro: BRANCH_STAT_EN adds taken/not-taken counters.
module branch_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm16,
  input  logic [3:0]  BranchOp,
  input  logic        cmp_taken,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        hold,
  input  logic        flush,
  output logic        id_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  state_o
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] nottaken_cnt
`endif
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_BZ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(3);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  state_t            state_q;
  logic              redirect_q;
  logic [PC_W-1:0]   redirect_pc_q;
  logic [PC_W-1:0]   target_d;

  logic              is_branch;
  logic              opnd_ready;
  logic              evaluating;
  logic              decide_ok;
  logic              take_br;
  logic              skip_br;

  // Branch decode, operand readiness and target computation for the ID instruction.
  always_comb begin
    is_branch  = 1'b0;
    opnd_ready = 1'b0;
    evaluating = 1'b0;
    decide_ok  = 1'b0;
    take_br    = 1'b0;
    skip_br    = 1'b0;
    target_d   = '0;

    is_branch  = id_valid & ((BranchOp == OP_BZ) | (BranchOp == OP_BEQ) |
                             (BranchOp == OP_BNE));
    opnd_ready = (BranchOp == OP_BZ) ? rs_ready : (rs_ready & rt_ready);
    // A branch sitting in the delay slot (REDIRECT) is never evaluated.
    evaluating = (state_q == IDLE) | (state_q == WAIT_OPND);
    decide_ok  = evaluating & ~flush & ~hold & is_branch & opnd_ready;
    take_br    = decide_ok & cmp_taken;
    skip_br    = decide_ok & ~cmp_taken;
    target_d   = id_pc + PC_W'(4) +
                 {{(PC_W-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};

    // Stall is not suppressed by hold: the operand wait still applies.
    id_stall   = evaluating & is_branch & ~opnd_ready & ~flush;
  end

  // Sequencer state, redirect request and target register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        IDLE, WAIT_OPND: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (hold) begin
            state_q <= state_q;
          end else if (is_branch & ~opnd_ready) begin
            state_q <= WAIT_OPND;
          end else if (take_br) begin
            state_q       <= REDIRECT;
            redirect_q    <= 1'b1;
            redirect_pc_q <= target_d;
          end else begin
            state_q <= IDLE;
          end
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STAT_EN
  logic [PC_W-1:0] taken_cnt_q;
  logic [PC_W-1:0] nottaken_cnt_q;

  // Resolved-branch statistics; both counters wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      if (take_br) taken_cnt_q    <= taken_cnt_q + PC_W'(1);
      if (skip_br) nottaken_cnt_q <= nottaken_cnt_q + PC_W'(1);
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

  // A flush in the redirect cycle cancels the fetch redirect immediately.
  assign redirect_valid = redirect_q & ~flush;
  assign redirect_pc    = redirect_pc_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed self-checking bench for branch_seq.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, well away from the next edge. Counter checks exist when BRANCH_STAT_EN is set.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [15:0] imm16;
  logic [3:0]  BranchOp;
  logic        cmp_taken;
  logic        rs_ready;
  logic        rt_ready;
  logic        hold;
  logic        flush;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  state_o;
`ifdef BRANCH_STAT_EN
  logic [31:0] taken_cnt;
  logic [31:0] nottaken_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  branch_seq dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .imm16          (imm16),
    .BranchOp       (BranchOp),
    .cmp_taken      (cmp_taken),
    .rs_ready       (rs_ready),
    .rt_ready       (rt_ready),
    .hold           (hold),
    .flush          (flush),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .state_o        (state_o)
`ifdef BRANCH_STAT_EN
    ,
    .taken_cnt      (taken_cnt),
    .nottaken_cnt   (nottaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock edge, then settle 1 unit for input updates.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered/combinational outputs after inputs settle.
  task automatic look(input string tag, input logic [1:0] st, input logic stall,
                      input logic rv, input logic [31:0] pc);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".stall"}, 32'(id_stall), 32'(stall));
    chk({tag, ".rv"},    32'(redirect_valid), 32'(rv));
    chk({tag, ".pc"},    redirect_pc, pc);
  endtask

  task automatic set_br(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                        input logic rs, input logic rt, input logic cmp);
    id_valid  = 1'b1;
    BranchOp  = op;
    id_pc     = pc;
    imm16     = imm;
    rs_ready  = rs;
    rt_ready  = rt;
    cmp_taken = cmp;
  endtask

  task automatic no_br();
    id_valid  = 1'b0;
    BranchOp  = 4'd0;
    cmp_taken = 1'b0;
    rs_ready  = 1'b1;
    rt_ready  = 1'b1;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_pc = '0; imm16 = '0; BranchOp = '0;
    cmp_taken = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    #2;
    look("reset", 2'd0, 1'b0, 1'b0, 32'h0);
`ifdef BRANCH_STAT_EN
    chk("reset.tcnt", taken_cnt, 32'd0);
    chk("reset.ncnt", nottaken_cnt, 32'd0);
`endif
    tick(); tick();
    reset = 1'b0;
    no_br();
    tick();

    // Ready beq taken: redirect one cycle after the decision edge.
    set_br(4'd2, 32'h0000_3000, 16'h0004, 1'b1, 1'b1, 1'b1);
    look("beq.D", 2'd0, 1'b0, 1'b0, 32'h0);
    tick();
    no_br();
    look("beq.D1", 2'd2, 1'b0, 1'b1, 32'h0000_3014);
    tick();
    look("beq.D2", 2'd0, 1'b0, 1'b0, 32'h0000_3014);

    // bne waiting on rt for three cycles.
    set_br(4'd3, 32'h0000_4000, 16'h0010, 1'b1, 1'b0, 1'b1);
    look("bne.w0", 2'd0, 1'b1, 1'b0, 32'h0000_3014);
    tick();
    look("bne.w1", 2'd1, 1'b1, 1'b0, 32'h0000_3014);
    tick();
    look("bne.w2", 2'd1, 1'b1, 1'b0, 32'h0000_3014);
    tick();
    rt_ready = 1'b1;
    look("bne.rdy", 2'd1, 1'b0, 1'b0, 32'h0000_3014);
    tick();
    no_br();
    look("bne.red", 2'd2, 1'b0, 1'b1, 32'h0000_4044);
    tick();

    // bgez with negative offset; a delay-slot branch is ignored.
    set_br(4'd1, 32'h0000_3008, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    look("bgez.D", 2'd0, 1'b0, 1'b0, 32'h0000_4044);
    tick();
    set_br(4'd2, 32'h0000_300C, 16'h0100, 1'b1, 1'b0, 1'b1);
    look("bgez.red", 2'd2, 1'b0, 1'b1, 32'h0000_3008);
    tick();
    no_br();
    look("slot.idle", 2'd0, 1'b0, 1'b0, 32'h0000_3008);

    // Ready beq not taken leaves the target alone.
    set_br(4'd2, 32'h0000_5000, 16'h0040, 1'b1, 1'b1, 1'b0);
    tick();
    no_br();
    look("nt", 2'd0, 1'b0, 1'b0, 32'h0000_3008);
`ifdef BRANCH_STAT_EN
    chk("nt.tcnt", taken_cnt, 32'd3);
    chk("nt.ncnt", nottaken_cnt, 32'd1);
`endif

    // Flush in the redirect cycle.
    set_br(4'd2, 32'h0000_6000, 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();
    no_br();
    flush = 1'b1;
    look("flr", 2'd2, 1'b0, 1'b0, 32'h0000_6004);
    tick();
    flush = 1'b0;
    look("flr.next", 2'd0, 1'b0, 1'b0, 32'h0000_6004);

    // Flush while waiting on operands.
    set_br(4'd3, 32'h0000_6100, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    flush = 1'b1;
    look("flw", 2'd1, 1'b0, 1'b0, 32'h0000_6004);
    tick();
    flush = 1'b0;
    no_br();
    look("flw.next", 2'd0, 1'b0, 1'b0, 32'h0000_6004);

    // Hold freezes a ready taken branch for two cycles.
    set_br(4'd2, 32'h0000_7000, 16'h0002, 1'b1, 1'b1, 1'b1);
    hold = 1'b1;
    tick();
    look("hold1", 2'd0, 1'b0, 1'b0, 32'h0000_6004);
    tick();
    look("hold2", 2'd0, 1'b0, 1'b0, 32'h0000_6004);
    hold = 1'b0;
    tick();
    no_br();
    look("hold.red", 2'd2, 1'b0, 1'b1, 32'h0000_700C);
`ifdef BRANCH_STAT_EN
    chk("hold.tcnt", taken_cnt, 32'd5);
`endif
    tick();

    // Non-branch opcodes and invalid ID never stall.
    set_br(4'd5, 32'h0000_8000, 16'h0000, 1'b0, 1'b0, 1'b1);
    look("op5", 2'd0, 1'b0, 1'b0, 32'h0000_700C);
    set_br(4'd2, 32'h0000_8000, 16'h0000, 1'b0, 1'b0, 1'b1);
    id_valid = 1'b0;
    look("inval", 2'd0, 1'b0, 1'b0, 32'h0000_700C);
    tick();
    look("inval.next", 2'd0, 1'b0, 1'b0, 32'h0000_700C);

    // Reset asserted mid-cycle while in WAIT_OPND.
    set_br(4'd3, 32'h0000_9000, 16'h0008, 1'b1, 1'b0, 1'b1);
    tick();
    look("rst.wait", 2'd1, 1'b1, 1'b0, 32'h0000_700C);
    reset = 1'b1;
    look("rst.async", 2'd0, 1'b1, 1'b0, 32'h0);
`ifdef BRANCH_STAT_EN
    chk("rst.tcnt", taken_cnt, 32'd0);
    chk("rst.ncnt", nottaken_cnt, 32'd0);
`endif
    tick();
    no_br();
    reset = 1'b0;
    tick();
    look("rst.after1", 2'd0, 1'b0, 1'b0, 32'h0);
    tick();
    look("rst.after2", 2'd0, 1'b0, 1'b0, 32'h0);

    // Target address wraps modulo 2^32.
    set_br(4'd2, 32'hFFFF_FFFC, 16'h0001, 1'b1, 1'b1, 1'b1);
    tick();
    no_br();
    look("wrap", 2'd2, 1'b0, 1'b1, 32'h0000_0004);
`ifdef BRANCH_STAT_EN
    chk("wrap.tcnt", taken_cnt, 32'd1);
`endif
    tick();
    look("wrap.idle", 2'd0, 1'b0, 1'b0, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
